// File: rtl/expr_harness_pkg.sv
// Shared types and constants for the vloghammer expression harness.
// fold90 is also used by the upstream stimulus generator's self-check.
package expr_harness_pkg;

   localparam int EXPR_Y_W   = 90;
   localparam int EXPR_SIG_W = 32;
   localparam int EXPR_CNT_W = 16;

   localparam logic [EXPR_SIG_W-1:0] EXPR_POLY = 32'h04C11DB7;
   localparam logic [EXPR_SIG_W-1:0] EXPR_SEED = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cmp_state_e;

   function automatic logic [EXPR_SIG_W-1:0] fold90(input logic [EXPR_Y_W-1:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b000000, y[89:64]};
   endfunction

endpackage

// File: rtl/expr_misr_step.sv
// One MISR step: shift with polynomial feedback, then XOR in the folded result vector.
module expr_misr_step
   import expr_harness_pkg::*;
#(
   parameter logic [EXPR_SIG_W-1:0] POLY = EXPR_POLY
) (
   input  logic [EXPR_SIG_W-1:0] sig_i,
   input  logic [EXPR_Y_W-1:0]   y_i,
   output logic [EXPR_SIG_W-1:0] sig_o
);

   logic [EXPR_SIG_W-1:0] feedback_s;

   // Next signature from current signature and result vector.
   always_comb begin
      if (sig_i[EXPR_SIG_W-1]) begin
         feedback_s = POLY;
      end else begin
         feedback_s = {EXPR_SIG_W{1'b0}};
      end
      sig_o = {sig_i[EXPR_SIG_W-2:0], 1'b0} ^ feedback_s ^ fold90(y_i);
   end

endmodule

// File: rtl/expr_sig_compactor.sv
// Folds a programmed number of 90-bit expression results into a 32-bit MISR
// signature and compares it against a golden value at the end of the run.
module expr_sig_compactor
   import expr_harness_pkg::*;
#(
   parameter int                    Y_W   = EXPR_Y_W,
   parameter int                    SIG_W = EXPR_SIG_W,
   parameter int                    CNT_W = EXPR_CNT_W,
   parameter logic [EXPR_SIG_W-1:0] POLY  = EXPR_POLY,
   parameter logic [EXPR_SIG_W-1:0] SEED  = EXPR_SEED
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic [SIG_W-1:0] golden,
   input  logic             in_valid,
   input  logic [Y_W-1:0]   in_y,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_count,
   output logic [SIG_W-1:0] signature,
   output logic             match
);

   cmp_state_e       state_q, state_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [SIG_W-1:0] gold_q, gold_d;
   logic [SIG_W-1:0] sig_step_s;
   logic [CNT_W-1:0] cnt_inc_s;

   expr_misr_step #(
      .POLY (POLY)
   ) u_step (
      .sig_i (sig_q),
      .y_i   (in_y),
      .sig_o (sig_step_s)
   );

   assign cnt_inc_s = cnt_q + CNT_W'(1);

   // Next-state decode; the final transfer and the move to DONE share one edge.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      gold_d  = gold_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sig_d  = SEED;
               cnt_d  = {CNT_W{1'b0}};
               num_d  = num_vec;
               gold_d = golden;
               if (num_vec == {CNT_W{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               sig_d = sig_step_s;
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == num_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and run registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         cnt_q   <= {CNT_W{1'b0}};
         num_q   <= {CNT_W{1'b0}};
         gold_q  <= {SIG_W{1'b0}};
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         gold_q  <= gold_d;
      end
   end

   assign in_ready  = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign vec_count = cnt_q;
   assign signature = sig_q;
   assign match     = done && (sig_q == gold_q);

endmodule

// File: doc/expr_sig_compactor.md
Name: expr_sig_compactor

Overview:
Downstream consumer for the 90-bit packed result bus of a vloghammer expression module. It accepts one result vector per valid/ready handshake and folds it into a 32-bit MISR signature over a programmed number of vectors. At the end of the run it compares the signature against a golden value. This lets regression compare RTL and synthesized netlists with one word per run instead of dumping every vector.

Parameters:
Y_W, 90, width of the consumed result bus
SIG_W, 32, signature width
CNT_W, 16, vector counter width
POLY, 32'h04C11DB7, MISR feedback polynomial (taps XORed in when the shifted-out MSB is 1)
SEED, 32'hFFFFFFFF, signature value loaded on reset and on each start

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE
num_vec  input  CNT_W  number of vectors in the run; sampled on start
golden  input  SIG_W  expected signature; sampled on start
in_valid  input  1  upstream has a result vector on in_y
in_y  input  Y_W  packed result {y0..y17} from the expression stage
in_ready  output  1  block accepts in_y this cycle
busy  output  1  high in RUN
done  output  1  high in DONE
vec_count  output  CNT_W  vectors accepted in the current run
signature  output  SIG_W  current MISR value
match  output  1  done && (signature == sampled golden)

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state = IDLE.
  - signature = SEED.
  - vec_count = 0; golden and num_vec registers = 0.
  - in_ready, busy, done and match = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE + start: load signature = SEED, vec_count = 0, and latch num_vec and golden.
    - If the latched num_vec = 0, go to DONE next cycle with signature = SEED.
    - Otherwise go to RUN.
  - RUN: in_ready = 1 (combinational from state only; independent of in_valid). A transfer is in_valid && in_ready.
    - Each transfer: signature <= misr(signature, fold(in_y)); vec_count <= vec_count + 1.
    - When a transfer brings vec_count to the latched num_vec, go to DONE. The final update lands in the same edge, so there is no extra latency.
    - in_valid low: hold all state. No timeout.
    - start while in RUN: ignored.
  - DONE: in_ready = 0; signature and vec_count are frozen; done = 1 until the next start.
    - start in DONE behaves exactly as start in IDLE (restart, re-seed).
- fold(y), for the 90-bit in_y:
  - Zero-extend to 96 bits.
  - Result = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
- misr(s, f) = ({s[30:0], 1'b0} ^ (s[31] ? POLY : 0)) ^ f. All arithmetic is unsigned.
- Latency:
  - A transfer on edge N is visible on signature and vec_count after edge N.
  - done rises on the edge following the last transfer.
- vec_count never wraps in a run: the maximum num_vec is 2^CNT_W−1, and the terminal compare fires first.
- match is registered-free: it is combinational from the done, signature and golden registers.
- Reset mid-run: aborts immediately to IDLE with reset values. No partial signature survives.
- in_y X while in_valid = 0: must not affect state.

Decomposition:
- Shared package expr_harness_pkg holds:
  - the FSM enum typedef;
  - the Y_W, SIG_W and CNT_W defaults;
  - the POLY and SEED constants;
  - a pure function fold90 reused by the upstream stimulus generator's self-check.
- One natural sub-module: expr_misr_step. It is combinational, computing next signature from (sig, y) including fold and feedback, so it can be unit-tested in isolation.

Test Plan:
- Reset, then start with num_vec=1, golden=32'hFB3EE249; one transfer with in_y=0 → signature=32'hFB3EE249, vec_count=1, done=1, match=1, in_ready=0.
- SEED overridden to 0; one transfer with in_y=90'h1 → signature=32'h00000001. Then in_y with bits 64 and 0 set → fold=0, signature=32'h00000002.
- start with num_vec=0 → DONE one cycle later, signature=32'hFFFFFFFF, vec_count=0, in_ready never asserted.
- num_vec=4 with in_valid toggling 1,0,0,1,1,0,1 → exactly 4 updates, done on the edge after the 4th transfer. Signature equals the software model of 4 misr steps. start pulsed mid-run has no effect.
- Assert reset asynchronously mid-RUN after 2 of 5 vectors → outputs drop to reset values before the next edge. A new start with num_vec=5 produces the same signature as an uninterrupted run.
- In DONE, pulse start with num_vec=2 and a golden deliberately off by one bit → done deasserts, run completes with match=0. The signature still equals the model value.
